conv_mac_writer: RTL and testbench

- Downstream stage of the convolution controller. Consumes a stream of window-pixel/filter-weight pairs (TAPS pairs per output point) from the 4x4 window buffer and filter buffer.
- Multiply-accumulates each window, then rounds, shifts and saturates the sum to 8 bits.
- Writes each result to output memory at sequential addresses, and signals done after NUM_OUT results.

---
 rtl/conv_pkg.sv | 27 ++
 rtl/conv_round_sat.sv | 49 ++++
 rtl/conv_mac_writer.sv | 152 +++++++++++++++
 tb/tb_conv_mac_writer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution MAC/writer stage.
package conv_pkg;

    localparam int unsigned TAPS    = 16;   // pixel/weight pairs per output point
    localparam int unsigned NUM_OUT = 169;  // output points per frame

    // Accumulator width: 17-bit product plus headroom for TAPS additions.
    function automatic int unsigned acc_w(input int unsigned taps);
        return 17 + $clog2(taps);
    endfunction

    localparam int unsigned ACC_W = acc_w(TAPS);

    typedef enum logic [2:0] {
        StIdle,
        StAcc,
        StScale,
        StWrite,
        StDone
    } state_e;

    typedef logic        [7:0]  pixel_t;
    typedef logic signed [7:0]  weight_t;
    typedef logic        [7:0]  result_t;
    typedef logic signed [16:0] prod_t;

endpackage

// File: rtl/conv_round_sat.sv
// Combinational round, arithmetic shift and saturate of the accumulator to one byte.
// Macro CONV_RELU_EN: when defined, the result is clamped to 0..255 (unsigned);
// otherwise it is clamped to -128..127 (two's complement).
module conv_round_sat #(
    parameter int unsigned ACC_W = 21,
    parameter int unsigned SHIFT = 4
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [7:0]       result
);

    localparam int unsigned RndPos = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] SMax  = (ACC_W + 1)'(127);
    localparam logic signed [ACC_W:0] SMin  = (ACC_W + 1)'(-128);
    localparam logic signed [ACC_W:0] UMax  = (ACC_W + 1)'(255);

    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] r;

    // Half-LSB rounding constant; zero when no shift is applied.
    always_comb begin
        rnd = '0;
        if (SHIFT > 0) rnd[RndPos] = 1'b1;
    end

    // One guard bit keeps the rounding add from overflowing.
    assign biased = $signed({acc[ACC_W-1], acc}) + rnd;
    assign r      = biased >>> SHIFT;

    // Clamp the shifted value into the output byte range.
    always_comb begin
        result = r[7:0];
`ifdef CONV_RELU_EN
        if (r[ACC_W]) begin
            result = 8'h00;
        end else if (r > UMax) begin
            result = 8'hFF;
        end
`else
        if (r > SMax) begin
            result = 8'h7F;
        end else if (r < SMin) begin
            result = 8'h80;
        end
`endif
    end

endmodule

// File: rtl/conv_mac_writer.sv
// Multiply-accumulates TAPS pixel/weight pairs per window, scales the sum to a
// byte and writes it to output memory at sequential addresses; pulses done after
// NUM_OUT results. Output clamping mode follows macro CONV_RELU_EN (see conv_round_sat).
module conv_mac_writer
    import conv_pkg::*;
#(
    parameter int unsigned TAPS     = conv_pkg::TAPS,
    parameter int unsigned NUM_OUT  = conv_pkg::NUM_OUT,
    parameter int unsigned SHIFT    = 4,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned OUT_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              tap_valid,
    output logic              tap_ready,
    input  logic [7:0]        tap_pixel,
    input  logic [7:0]        tap_weight,
    input  logic              tap_last,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned       AccW     = acc_w(TAPS);
    localparam int unsigned       TapW     = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned       CntW     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [TapW-1:0]   TapLast  = TapW'(TAPS - 1);
    localparam logic [CntW-1:0]   OutLast  = CntW'(NUM_OUT - 1);
    localparam logic [ADDR_W-1:0] AddrBase = ADDR_W'(OUT_BASE);

    state_e                 state_q, state_d;
    logic signed [AccW-1:0] acc_q, acc_d;
    logic [TapW-1:0]        tap_cnt_q, tap_cnt_d;
    logic [CntW-1:0]        out_cnt_q, out_cnt_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic                   err_q, err_d;

    logic signed [8:0]      px_s;
    weight_t                wt_s;
    prod_t                  prod;
    result_t                scaled;
    logic                   tap_fire;

    // Pixel is unsigned: zero-extend to 9-bit signed before the signed multiply.
    assign px_s = {1'b0, tap_pixel};
    assign wt_s = tap_weight;
    assign prod = 17'(px_s) * 17'(wt_s);

    assign tap_ready = (state_q == StAcc);
    assign wr_valid  = (state_q == StWrite);
    assign done      = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign err       = err_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign tap_fire  = tap_valid && tap_ready;

    conv_round_sat #(
        .ACC_W (AccW),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .acc    (acc_q),
        .result (scaled)
    );

    // Next-state and datapath updates for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        tap_cnt_d = tap_cnt_q;
        out_cnt_d = out_cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StAcc;
                    acc_d     = '0;
                    tap_cnt_d = '0;
                    out_cnt_d = '0;
                    wr_addr_d = AddrBase;
                end
            end
            StAcc: begin
                if (tap_fire) begin
                    acc_d = acc_q + AccW'(prod);
                    // Window boundaries come from tap_cnt; tap_last only flags errors.
                    if (tap_cnt_q == TapLast) begin
                        tap_cnt_d = '0;
                        state_d   = StScale;
                        if (!tap_last) err_d = 1'b1;
                    end else begin
                        tap_cnt_d = tap_cnt_q + 1'b1;
                        if (tap_last) err_d = 1'b1;
                    end
                end
            end
            StScale: begin
                wr_data_d = scaled;
                state_d   = StWrite;
            end
            StWrite: begin
                if (wr_ready) begin
                    if (out_cnt_q == OutLast) begin
                        state_d = StDone;
                    end else begin
                        state_d   = StAcc;
                        out_cnt_d = out_cnt_q + 1'b1;
                        wr_addr_d = wr_addr_q + 1'b1;
                        acc_d     = '0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register; reset aborts any frame in progress at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            tap_cnt_q <= '0;
            out_cnt_q <= '0;
            wr_addr_q <= AddrBase;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            tap_cnt_q <= tap_cnt_d;
            out_cnt_q <= out_cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_conv_mac_writer.sv
// Randomised bench for conv_mac_writer against a behavioural arithmetic model.
module tb_conv_mac_writer;

    localparam int TAPS     = 16;
    localparam int NUM_OUT  = 169;
    localparam int SHIFT    = 4;
    localparam int ADDR_W   = 8;
    localparam int OUT_BASE = 0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              tap_valid = 1'b0;
    logic              tap_ready;
    logic [7:0]        tap_pixel = 8'd0;
    logic [7:0]        tap_weight = 8'd0;
    logic              tap_last = 1'b0;
    logic              wr_valid;
    logic              wr_ready = 1'b0;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              done;
    logic              err;

    int n_vec = 0;
    int n_err = 0;
    int px[TAPS];
    int wt[TAPS];

    conv_mac_writer #(
        .TAPS     (TAPS),
        .NUM_OUT  (NUM_OUT),
        .SHIFT    (SHIFT),
        .ADDR_W   (ADDR_W),
        .OUT_BASE (OUT_BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .tap_valid  (tap_valid),
        .tap_ready  (tap_ready),
        .tap_pixel  (tap_pixel),
        .tap_weight (tap_weight),
        .tap_last   (tap_last),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected output byte: exact sum, round-half-up, floor division, clamp.
    function automatic logic [7:0] model();
        longint a, d, q;
        a = 0;
        for (int i = 0; i < TAPS; i++) a += longint'(px[i]) * longint'(wt[i]);
        d = longint'(1) << SHIFT;
        if (SHIFT > 0) a += d / 2;
        q = a / d;
        if ((a % d) != 0 && a < 0) q -= 1;
`ifdef CONV_RELU_EN
        if (q < 0) q = 0;
        if (q > 255) q = 255;
`else
        if (q > 127) q = 127;
        if (q < -128) q = -128;
`endif
        return 8'(q);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int p, input int w);
        for (int i = 0; i < TAPS; i++) begin
            px[i] = p;
            wt[i] = w;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < TAPS; i++) begin
            px[i] = int'($urandom_range(0, 255));
            wt[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // Feeds one window and leaves the DUT presenting its write (wr_ready low).
    task automatic run_window(input int k, input int hold, input int bad_last, input bit gaps);
        logic [7:0]        exp_d;
        logic [ADDR_W-1:0] exp_a;
        int                guard;
        bit                was;
        exp_d = model();
        exp_a = ADDR_W'(OUT_BASE + k);
        for (int i = 0; i < TAPS; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            tap_valid  = 1'b1;
            tap_pixel  = 8'(px[i]);
            tap_weight = 8'(wt[i]);
            tap_last   = (i == TAPS - 1) != (i == bad_last);
            guard = 0;
            was   = 1'b0;
            while (!was && guard < 50) begin
                was = tap_ready;
                tick();
                guard++;
            end
            tap_valid = 1'b0;
            tap_last  = 1'b0;
            if (!was) begin
                check("tap_timeout", 0, 1);
                return;
            end
            if (i == bad_last) check("err_set", err, 1);
        end
        check("lat_scale_valid", wr_valid, 0);
        tick();
        check("lat_write_valid", wr_valid, 1);
        check("wr_addr", wr_addr, exp_a);
        check("wr_data", wr_data, exp_d);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("bp_valid", wr_valid, 1);
            check("bp_addr", wr_addr, exp_a);
            check("bp_data", wr_data, exp_d);
            check("bp_tap_ready", tap_ready, 0);
        end
    endtask

    task automatic finish_write(input bit last);
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        check("post_hs_valid", wr_valid, 0);
        check("done", done, last);
        if (last) begin
            check("busy_in_done", busy, 1);
            tick();
            check("done_pulse_end", done, 0);
            check("busy_idle", busy, 0);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("tap_ready_acc", tap_ready, 1);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_tap_ready", tap_ready, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_addr", wr_addr, ADDR_W'(OUT_BASE));
        check("rst_wr_data", wr_data, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Frame 1: directed windows first, then random with gaps and stray starts
        do_start();
        for (int k = 0; k < NUM_OUT; k++) begin
            int hold;
            hold = int'($urandom_range(0, 2));
            case (k)
                0:       fill(1, 1);
                1:       fill(255, 127);
                2:       fill(10, -1);
                default: fill_random();
            endcase
            if (k == 3) hold = 5;
            if (k == 4 || k == 50) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            run_window(k, hold, -1, k > 3);
            finish_write(k == NUM_OUT - 1);
        end
        check("frame1_err", err, 0);

        // Frame 2: framing error, then reset while a write is pending
        do_start();
        fill_random();
        run_window(0, 0, 5, 1'b0);
        check("err_sticky", err, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_wr_valid", wr_valid, 0);
        check("rst_mid_err", err, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_addr", wr_addr, ADDR_W'(OUT_BASE));
        tick();
        rst = 1'b0;
        tick();

        // Frame 3: full random frame after reset
        do_start();
        for (int k = 0; k < NUM_OUT; k++) begin
            fill_random();
            run_window(k, int'($urandom_range(0, 1)), -1, 1'b1);
            finish_write(k == NUM_OUT - 1);
        end
        check("frame3_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
